ysyx_23060203_dmem_resp: RTL and testbench

Data-memory responder: the slave end of the EXU load/store port. Accepts one read or write request per transaction over a valid/ready handshake, applies RV32 byte-lane rules for the load/store function codes, and returns read data after a programmable latency. It sits behind the EXU/LSU as the on-chip data SRAM model and replaces the purely combinational memory read path.

---
 rtl/ysyx_23060203_dmem_resp.sv | 213 +++++++++++++++++++++
 tb/tb_ysyx_23060203_dmem_resp.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060203_dmem_resp.sv
// Data-memory responder: valid/ready slave port with RV32 byte-lane load/store rules and programmable response latency.
// Define DMEM_MISALIGN_CHECK_EN to flag misaligned halfword/word accesses as errors instead of force-aligning them.
module ysyx_23060203_dmem_resp #(
  parameter logic [31:0] ADDR_BASE  = 32'h8000_0000,
  parameter int unsigned DEPTH_LOG2 = 16,
  parameter int unsigned LATENCY    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_ren,
  input  logic        req_wen,
  input  logic [2:0]  req_func,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0]  LAT   = 4'(LATENCY);
  localparam logic [32:0] SPAN  = 33'd4 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ren_q, ren_d;
  logic        wen_q, wen_d;
  logic [2:0]  func_q, func_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        do_access;

  logic [31:0] mem [DEPTH];

  // With zero latency the access happens in the acceptance cycle, so it must
  // see the live request rather than the not-yet-latched copy.
  logic        acc_ren, acc_wen;
  logic [2:0]  acc_func;
  logic [31:0] acc_addr, acc_wdata;

  assign acc_ren   = (state_q == IDLE) ? req_ren   : ren_q;
  assign acc_wen   = (state_q == IDLE) ? req_wen   : wen_q;
  assign acc_func  = (state_q == IDLE) ? req_func  : func_q;
  assign acc_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign acc_wdata = (state_q == IDLE) ? req_wdata : wdata_q;

  logic [31:0]           offset;
  logic                  in_range;
  logic                  func_ok;
  logic                  misalign;
  logic                  acc_err;
  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0]           word;
  logic [7:0]            lane_byte;
  logic [15:0]           lane_half;
  logic [31:0]           load_val;
  logic [31:0]           wword;
  logic [3:0]            wmask;
  logic                  mem_we;

  always_comb begin
    offset   = acc_addr - ADDR_BASE;
    in_range = (acc_addr >= ADDR_BASE) && ({1'b0, offset} < SPAN);
    idx      = offset[DEPTH_LOG2+1:2];

    if (acc_wen) begin
      func_ok = !acc_func[2] && (acc_func[1:0] != 2'b11);
    end else begin
      func_ok = (acc_func[1:0] != 2'b11) && (acc_func != 3'b110);
    end

`ifdef DMEM_MISALIGN_CHECK_EN
    misalign = ((acc_func[1:0] == 2'b01) && acc_addr[0]) ||
               ((acc_func[1:0] == 2'b10) && (acc_addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif

    acc_err = (acc_ren || acc_wen) &&
              (!in_range || (acc_ren && acc_wen) || !func_ok || misalign);

    word = mem[idx];

    case (acc_addr[1:0])
      2'b00:   lane_byte = word[7:0];
      2'b01:   lane_byte = word[15:8];
      2'b10:   lane_byte = word[23:16];
      default: lane_byte = word[31:24];
    endcase
    lane_half = acc_addr[1] ? word[31:16] : word[15:0];

    case (acc_func[1:0])
      2'b00:   load_val = acc_func[2] ? {24'd0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
      2'b01:   load_val = acc_func[2] ? {16'd0, lane_half} : {{16{lane_half[15]}}, lane_half};
      default: load_val = word;
    endcase

    case (acc_func[1:0])
      2'b00: begin
        wmask = 4'b0001 << acc_addr[1:0];
        wword = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        wmask = acc_addr[1] ? 4'b1100 : 4'b0011;
        wword = {2{acc_wdata[15:0]}};
      end
      default: begin
        wmask = 4'b1111;
        wword = acc_wdata;
      end
    endcase
  end

  // Gating on rst keeps a store from landing on the same edge a reset is raised.
  assign mem_we = do_access && acc_wen && !acc_err && !rst;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wmask[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ren_d     = ren_q;
    wen_d     = wen_q;
    func_d    = func_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    do_access = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          ren_d   = req_ren;
          wen_d   = req_wen;
          func_d  = req_func;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = LAT;
          if (LAT == 4'd0) begin
            state_d   = RESP;
            do_access = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d   = RESP;
          do_access = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (do_access) begin
      rdata_d = (acc_ren && !acc_err) ? load_val : '0;
      err_d   = acc_err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      func_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      func_q  <= func_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_ysyx_23060203_dmem_resp.sv
// Directed bench for ysyx_23060203_dmem_resp: one instance at LATENCY=1, one at LATENCY=3.
// Misaligned-access expectations follow DMEM_MISALIGN_CHECK_EN.
module tb_ysyx_23060203_dmem_resp;

  localparam int unsigned LAT0 = 1;
  localparam int unsigned LAT1 = 3;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  logic        clk;
  logic        rst;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_ren    [2];
  logic        req_wen    [2];
  logic [2:0]  req_func   [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  int n_chk;
  int n_bad;

  ysyx_23060203_dmem_resp #(.LATENCY(LAT0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_ren(req_ren[0]), .req_wen(req_wen[0]), .req_func(req_func[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  ysyx_23060203_dmem_resp #(.LATENCY(LAT1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_ren(req_ren[1]), .req_wen(req_wen[1]), .req_func(req_func[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag, input int d);
    check({tag, ".req_ready"},  {31'd0, req_ready[d]},  32'd1);
    check({tag, ".resp_valid"}, {31'd0, resp_valid[d]}, 32'd0);
    check({tag, ".resp_rdata"}, resp_rdata[d],          32'd0);
    check({tag, ".resp_err"},   {31'd0, resp_err[d]},   32'd0);
  endtask

  // Presents one request; returns once resp_valid is seen (#1 after an edge).
  // lat counts rising edges from the acceptance edge inclusive.
  task automatic xact(input int d, input logic ren, input logic wen, input logic [2:0] f,
                      input logic [31:0] a, input logic [31:0] wd, input logic rdy,
                      output logic [31:0] rd, output logic er, output int lat);
    req_valid[d]  = 1'b1;
    req_ren[d]    = ren;
    req_wen[d]    = wen;
    req_func[d]   = f;
    req_addr[d]   = a;
    req_wdata[d]  = wd;
    resp_ready[d] = rdy;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    req_ren[d]   = 1'b0;
    req_wen[d]   = 1'b0;
    req_func[d]  = '0;
    req_addr[d]  = '0;
    req_wdata[d] = '0;
    lat = 1;
    while (!resp_valid[d] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!resp_valid[d]) check("timeout", {31'd0, resp_valid[d]}, 32'd1);
    rd = resp_rdata[d];
    er = resp_err[d];
  endtask

  task automatic do_op(input string tag, input int d, input logic ren, input logic wen,
                       input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    int          lat;
    xact(d, ren, wen, f, a, wd, 1'b1, rd, er, lat);
    check({tag, ".rdata"}, rd, exp_rd);
    check({tag, ".err"}, {31'd0, er}, {31'd0, exp_err});
    check({tag, ".lat"}, 32'(lat), 32'((d == 0 ? LAT0 : LAT1) + 1));
    @(posedge clk); #1;
    check({tag, ".ready_after"}, {31'd0, req_ready[d]}, 32'd1);
    resp_ready[d] = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;

    n_chk = 0;
    n_bad = 0;
    rst   = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_valid[i]  = 1'b0;
      req_ren[i]    = 1'b0;
      req_wen[i]    = 1'b0;
      req_func[i]   = '0;
      req_addr[i]   = '0;
      req_wdata[i]  = '0;
      resp_ready[i] = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    check_idle_outputs("reset0", 0);
    check_idle_outputs("reset1", 1);
    rst = 1'b0;
    @(posedge clk); #1;

    // word store/load round trip
    do_op("sw10", 0, 1'b0, 1'b1, F_W, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0);
    do_op("lw10", 0, 1'b1, 1'b0, F_W, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);

    // byte lanes and extension
    do_op("sw00",  0, 1'b0, 1'b1, F_W,  32'h8000_0000, 32'h0000_0000, 32'h0, 1'b0);
    do_op("sb03",  0, 1'b0, 1'b1, F_B,  32'h8000_0003, 32'h0000_0080, 32'h0, 1'b0);
    do_op("lb03",  0, 1'b1, 1'b0, F_B,  32'h8000_0003, 32'h0, 32'hFFFF_FF80, 1'b0);
    do_op("lbu03", 0, 1'b1, 1'b0, F_BU, 32'h8000_0003, 32'h0, 32'h0000_0080, 1'b0);
    do_op("lw00",  0, 1'b1, 1'b0, F_W,  32'h8000_0000, 32'h0, 32'h8000_0000, 1'b0);
    do_op("sb11",  0, 1'b0, 1'b1, F_B,  32'h8000_0011, 32'hFFFF_FF80, 32'h0, 1'b0);
    do_op("lb11",  0, 1'b1, 1'b0, F_B,  32'h8000_0011, 32'h0, 32'hFFFF_FF80, 1'b0);
    do_op("lb13",  0, 1'b1, 1'b0, F_B,  32'h8000_0013, 32'h0, 32'hFFFF_FFDE, 1'b0);
    do_op("lbu12", 0, 1'b1, 1'b0, F_BU, 32'h8000_0012, 32'h0, 32'h0000_00AD, 1'b0);
    do_op("lw10b", 0, 1'b1, 1'b0, F_W,  32'h8000_0010, 32'h0, 32'hDEAD_80EF, 1'b0);

    // halfword lanes
    do_op("sw20",  0, 1'b0, 1'b1, F_W,  32'h8000_0020, 32'h1234_5678, 32'h0, 1'b0);
    do_op("sh22",  0, 1'b0, 1'b1, F_H,  32'h8000_0022, 32'h0000_8001, 32'h0, 1'b0);
    do_op("lh22",  0, 1'b1, 1'b0, F_H,  32'h8000_0022, 32'h0, 32'hFFFF_8001, 1'b0);
    do_op("lhu22", 0, 1'b1, 1'b0, F_HU, 32'h8000_0022, 32'h0, 32'h0000_8001, 1'b0);
    do_op("lh20",  0, 1'b1, 1'b0, F_H,  32'h8000_0020, 32'h0, 32'h0000_5678, 1'b0);
    do_op("lw20",  0, 1'b1, 1'b0, F_W,  32'h8000_0020, 32'h0, 32'h8001_5678, 1'b0);

    // range boundaries and illegal requests
    do_op("lw_below",  0, 1'b1, 1'b0, F_W, 32'h7FFF_FFFC, 32'h0, 32'h0, 1'b1);
    do_op("sw_below",  0, 1'b0, 1'b1, F_W, 32'h7FFF_FFFC, 32'h1, 32'h0, 1'b1);
    do_op("sw_above",  0, 1'b0, 1'b1, F_W, 32'h8004_0000, 32'h1, 32'h0, 1'b1);
    do_op("sw_last",   0, 1'b0, 1'b1, F_W, 32'h8003_FFFC, 32'hA5A5_A5A5, 32'h0, 1'b0);
    do_op("lw_last",   0, 1'b1, 1'b0, F_W, 32'h8003_FFFC, 32'h0, 32'hA5A5_A5A5, 1'b0);
    do_op("rw_both",   0, 1'b1, 1'b1, F_W, 32'h8000_0020, 32'hFFFF_FFFF, 32'h0, 1'b1);
    do_op("lw20_keep", 0, 1'b1, 1'b0, F_W, 32'h8000_0020, 32'h0, 32'h8001_5678, 1'b0);
    do_op("ld_f011",   0, 1'b1, 1'b0, 3'b011, 32'h8000_0010, 32'h0, 32'h0, 1'b1);
    do_op("ld_f110",   0, 1'b1, 1'b0, 3'b110, 32'h8000_0010, 32'h0, 32'h0, 1'b1);
    do_op("st_f100",   0, 1'b0, 1'b1, 3'b100, 32'h8000_0020, 32'h0, 32'h0, 1'b1);
    do_op("lw20_kp2",  0, 1'b1, 1'b0, F_W, 32'h8000_0020, 32'h0, 32'h8001_5678, 1'b0);
    do_op("noop",      0, 1'b0, 1'b0, F_W, 32'h8000_0020, 32'h0, 32'h0, 1'b0);

    // misaligned halfword/word accesses
    do_op("sw30", 0, 1'b0, 1'b1, F_W, 32'h8000_0030, 32'hCAFE_F00D, 32'h0, 1'b0);
`ifdef DMEM_MISALIGN_CHECK_EN
    do_op("lw32_mis",  0, 1'b1, 1'b0, F_W,  32'h8000_0032, 32'h0, 32'h0, 1'b1);
    do_op("sh31_mis",  0, 1'b0, 1'b1, F_H,  32'h8000_0031, 32'h0000_BEEF, 32'h0, 1'b1);
    do_op("lw30_mis",  0, 1'b1, 1'b0, F_W,  32'h8000_0030, 32'h0, 32'hCAFE_F00D, 1'b0);
    do_op("lh33_mis",  0, 1'b1, 1'b0, F_H,  32'h8000_0033, 32'h0, 32'h0, 1'b1);
    do_op("lhu33_mis", 0, 1'b1, 1'b0, F_HU, 32'h8000_0033, 32'h0, 32'h0, 1'b1);
`else
    do_op("lw32_mis",  0, 1'b1, 1'b0, F_W,  32'h8000_0032, 32'h0, 32'hCAFE_F00D, 1'b0);
    do_op("sh31_mis",  0, 1'b0, 1'b1, F_H,  32'h8000_0031, 32'h0000_BEEF, 32'h0, 1'b0);
    do_op("lw30_mis",  0, 1'b1, 1'b0, F_W,  32'h8000_0030, 32'h0, 32'hCAFE_BEEF, 1'b0);
    do_op("lh33_mis",  0, 1'b1, 1'b0, F_H,  32'h8000_0033, 32'h0, 32'hFFFF_CAFE, 1'b0);
    do_op("lhu33_mis", 0, 1'b1, 1'b0, F_HU, 32'h8000_0033, 32'h0, 32'h0000_CAFE, 1'b0);
`endif

    // response held under back-pressure
    xact(0, 1'b1, 1'b0, F_W, 32'h8000_0010, 32'h0, 1'b0, rd, er, lat);
    check("bp.rdata", rd, 32'hDEAD_80EF);
    check("bp.err", {31'd0, er}, 32'd0);
    check("bp.lat", 32'(lat), 32'(LAT0 + 1));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp.hold_valid", {31'd0, resp_valid[0]}, 32'd1);
      check("bp.hold_rdata", resp_rdata[0], 32'hDEAD_80EF);
      check("bp.hold_err",   {31'd0, resp_err[0]}, 32'd0);
      check("bp.hold_ready", {31'd0, req_ready[0]}, 32'd0);
    end
    resp_ready[0] = 1'b1;
    @(posedge clk); #1;
    check("bp.rel_valid", {31'd0, resp_valid[0]}, 32'd0);
    check("bp.rel_ready", {31'd0, req_ready[0]}, 32'd1);
    resp_ready[0] = 1'b0;

    // LATENCY=3 instance: reset during WAIT drops the store
    do_op("l3.sw40", 1, 1'b0, 1'b1, F_W, 32'h8000_0040, 32'h0BAD_F00D, 32'h0, 1'b0);
    do_op("l3.lw40", 1, 1'b1, 1'b0, F_W, 32'h8000_0040, 32'h0, 32'h0BAD_F00D, 1'b0);
    req_valid[1] = 1'b1;
    req_ren[1]   = 1'b0;
    req_wen[1]   = 1'b1;
    req_func[1]  = F_W;
    req_addr[1]  = 32'h8000_0040;
    req_wdata[1] = 32'h1234_5678;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    req_wen[1]   = 1'b0;
    check("l3.wait_ready", {31'd0, req_ready[1]}, 32'd0);
    check("l3.wait_valid", {31'd0, resp_valid[1]}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_idle_outputs("l3.rst_wait", 1);
    @(negedge clk);
    rst = 1'b0;
    do_op("l3.lw40_old", 1, 1'b1, 1'b0, F_W, 32'h8000_0040, 32'h0, 32'h0BAD_F00D, 1'b0);

    // reset during RESP keeps the committed store
    xact(1, 1'b0, 1'b1, F_W, 32'h8000_0044, 32'h55AA_55AA, 1'b0, rd, er, lat);
    check("l3.sw44.err", {31'd0, er}, 32'd0);
    check("l3.sw44.lat", 32'(lat), 32'(LAT1 + 1));
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_idle_outputs("l3.rst_resp", 1);
    @(negedge clk);
    rst = 1'b0;
    do_op("l3.lw44", 1, 1'b1, 1'b0, F_W, 32'h8000_0044, 32'h0, 32'h55AA_55AA, 1'b0);

    // memory persists across reset on the LATENCY=1 instance too
    do_op("lw10_post", 0, 1'b1, 1'b0, F_W, 32'h8000_0010, 32'h0, 32'hDEAD_80EF, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
